// File: rtl/matrix_scanner.sv
// matrix_scanner: captures a 128-bit digit bitmap once per frame, scans the
// LED matrix one row at a time, and serialises each row's 16 column bits into
// a 74HC595-style shift chain (data / shift clock / latch).
module matrix_scanner #(
  parameter int CLK_DIV  = 4,     // clk cycles per sr_clk half-period and latch width
  parameter int ROW_HOLD = 1000   // clk cycles each row stays lit
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_t,
  output logic         sr_data,
  output logic         sr_clk,
  output logic         sr_latch,
  output logic [7:0]   row_en,
  output logic         frame_done
);

  localparam int DW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, DISPLAY} state_t;

  state_t         state, state_nx;
  logic [127:0]   frame;
  logic [2:0]     row;
  logic [15:0]    shreg;
  logic [3:0]     bitcnt;
  logic           phase;     // 0 = sr_clk low half, 1 = high half
  logic [DW-1:0]  div;
  logic [HW-1:0]  hold;
  logic           div_last, hold_last;

  assign div_last  = (div  == DW'(CLK_DIV - 1));
  assign hold_last = (hold == HW'(ROW_HOLD - 1));

  // Row r sits at the top of the bitmap shifted left by 16*r bits.
  function automatic logic [15:0] row_word(input logic [127:0] f, input logic [2:0] r);
    logic [127:0] s;
    s = f << {r, 4'b0000};
    return s[127:112];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Next-state and pin decode; outputs are pure functions of state and counters.
  always_comb begin
    state_nx   = state;
    sr_data    = 1'b0;
    sr_clk     = 1'b0;
    sr_latch   = 1'b0;
    row_en     = 8'h00;
    frame_done = 1'b0;
    case (state)
      LOAD:    state_nx = SHIFT;
      SHIFT: begin
        sr_data = shreg[15];
        sr_clk  = phase;
        if (div_last && phase && bitcnt == 4'd15) state_nx = LATCH;
      end
      LATCH: begin
        sr_latch = 1'b1;
        if (div_last) state_nx = DISPLAY;
      end
      DISPLAY: begin
        row_en     = 8'b1 << row;
        frame_done = hold_last && (row == 3'd7);
        if (hold_last) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Datapath: frame capture, row shift register and the three counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame  <= '0;
      row    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      phase  <= 1'b0;
      div    <= '0;
      hold   <= '0;
    end else begin
      case (state)
        LOAD: begin
          // Frame is only refreshed at row 0 so a frame is always coherent.
          if (row == 3'd0) begin
            frame <= data_t;
            shreg <= row_word(data_t, row);
          end else begin
            shreg <= row_word(frame, row);
          end
          bitcnt <= '0;
          phase  <= 1'b0;
          div    <= '0;
        end
        SHIFT: begin
          if (div_last) begin
            div   <= '0;
            phase <= ~phase;
            // Next bit appears exactly when sr_clk falls back low.
            if (phase) begin
              shreg  <= {shreg[14:0], 1'b0};
              bitcnt <= bitcnt + 4'd1;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        LATCH: begin
          div  <= div_last ? '0 : div + DW'(1);
          hold <= '0;
        end
        DISPLAY: begin
          if (hold_last) begin
            hold <= '0;
            row  <= row + 3'd1;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scanner.sv
// Bench for matrix_scanner: a cycle-position model (derived from row/frame
// period arithmetic) checks every output of two instances each cycle, a
// shift-chain model reconstructs latched words, and literal expectations pin
// the row mapping, coherence and reset behaviour.
module tb_matrix_scanner;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data_t = '0;
  logic [1:0]   sd, sc, sl, fd;
  logic [7:0]   re [2];

  // Instance 0: fast timing; instance 1: default parameters.
  matrix_scanner #(.CLK_DIV(1), .ROW_HOLD(2)) u_fast (
    .clk(clk), .rst(rst), .data_t(data_t),
    .sr_data(sd[0]), .sr_clk(sc[0]), .sr_latch(sl[0]),
    .row_en(re[0]), .frame_done(fd[0]));

  matrix_scanner u_def (
    .clk(clk), .rst(rst), .data_t(data_t),
    .sr_data(sd[1]), .sr_clk(sc[1]), .sr_latch(sl[1]),
    .row_en(re[1]), .frame_done(fd[1]));

  always #5 clk = ~clk;

  localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [15:0] ROWS [8] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF,
                                       16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
  localparam logic [7:0]  RENS [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                       8'h10, 8'h20, 8'h40, 8'h80};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  typedef struct packed {
    logic       clk, dat, dv, lat, fd;
    logic [7:0] ren;
  } exp_t;

  function automatic logic [15:0] roww(input logic [127:0] f, input int r);
    return f[127 - 16*r -: 16];
  endfunction

  // Expected pins for cycle c after the last reset, from the row-period layout:
  // 1 load cycle, 32*D shift cycles, D latch cycles, H display cycles.
  function automatic exp_t model(input int c, input int d, input int h, input logic [127:0] f);
    exp_t e;
    int per, p, r, q, b;
    e   = '0;
    per = 1 + 33*d + h;
    p   = c % per;
    r   = (c / per) % 8;
    if (p == 0) begin
      e = '0;
    end else if (p <= 32*d) begin
      q     = p - 1;
      b     = q / (2*d);
      e.clk = ((q % (2*d)) >= d);
      e.dv  = 1'b1;
      e.dat = f[127 - 16*r - b];
    end else if (p <= 33*d) begin
      e.lat = 1'b1;
    end else begin
      e.ren = 8'h01 << r;
      e.fd  = (p == per - 1) && (r == 7);
    end
    return e;
  endfunction

  int dv [2] = '{1, 4};
  int hv [2] = '{2, 1000};
  int gap[2] = '{288, 9064};

  logic [127:0] fm [2];
  bit           cap [2];
  bit           rst_e = 1'b1;
  int           c = 0;
  int           ncyc = 0;
  logic [15:0]  chain [2];
  int           nrise [2];
  logic         pc [2], pl [2];
  int           lastfd [2];
  bit           hasfd [2];
  int           ngap [2];
  logic [15:0]  lat1 [8];

  // Reset as the DUT saw it at the edge that starts the current cycle.
  always @(posedge clk) rst_e <= rst;

  // Frame register model: loads at the row-0 LOAD edge.
  always @(posedge clk) for (int i = 0; i < 2; i++) if (cap[i]) fm[i] <= data_t;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : cmp
    exp_t e;
    int per, p, r;
    ncyc++;
    if (rst_e) c = 0; else c++;
    for (int i = 0; i < 2; i++) begin
      per = 1 + 33*dv[i] + hv[i];
      p   = c % per;
      r   = (c / per) % 8;
      e   = model(c, dv[i], hv[i], fm[i]);
      if (rst_e) begin
        nrise[i] = 0; chain[i] = '0; hasfd[i] = 1'b0; pc[i] = 1'b0; pl[i] = 1'b0;
        chk("rst_sr_data", sd[i], 0);
      end
      chk("sr_clk", sc[i], e.clk);
      chk("sr_latch", sl[i], e.lat);
      chk("row_en", re[i], e.ren);
      chk("frame_done", fd[i], e.fd);
      if (e.dv) chk("sr_data", sd[i], e.dat);
      chk("onehot0", $onehot0(re[i]), 1);
      chk("blanking", ((sc[i] | sl[i]) && re[i] != 8'h00), 0);
      // Shift-chain model: sample on sr_clk rise, capture on sr_latch rise.
      if (sc[i] && !pc[i]) begin
        chain[i] = {chain[i][14:0], sd[i]};
        nrise[i]++;
      end
      if (sl[i] && !pl[i]) begin
        chk("rises_per_latch", nrise[i], 16);
        chk("latched_word", chain[i], roww(fm[i], r));
        if (i == 0) lat1[r] = chain[i];
        nrise[i] = 0;
      end
      if (fd[i]) begin
        if (hasfd[i]) begin
          chk("frame_gap", ncyc - lastfd[i], gap[i]);
          ngap[i]++;
        end
        hasfd[i]  = 1'b1;
        lastfd[i] = ncyc;
      end
      pc[i]  = sc[i];
      pl[i]  = sl[i];
      cap[i] = (p == 0) && (r == 0);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_c(input int t);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (c != t && n < 50000);
    if (c != t) begin
      total++; bad++;
      $display("FAIL wait_c: reached %0d want %0d", c, t);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int base;
    rst = 1'b1;
    data_t = PAT;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outs", {sd[0], sc[0], sl[0], fd[0], re[0]}, 0);
    rst = 1'b0;

    // Row mapping and display order on the fast instance.
    for (int k = 0; k < 8; k++) begin
      wait_c(36*k + 34);
      chk("row_en_lit", re[0], RENS[k]);
    end
    wait_c(287);
    chk("frame_done_lit", fd[0], 1);
    wait_c(290);
    for (int k = 0; k < 8; k++) chk("row_map_lit", lat1[k], ROWS[k]);

    // Frame coherence: ones captured at frame 2, switched to zeros in row 3.
    data_t = {128{1'b1}};
    wait_c(576 + 3*36 + 34);
    data_t = '0;
    wait_c(864 + 2);
    for (int k = 0; k < 8; k++) chk("coherent_ones", lat1[k], 16'hFFFF);
    wait_c(1152 + 2);
    for (int k = 0; k < 8; k++) chk("next_frame_zero", lat1[k], 16'h0000);

    // Random frames, data changing at arbitrary points.
    while (c < 1152 + 20*288) begin
      data_t = rnd128();
      wait_n($urandom_range(1, 400));
    end

    // Reset during row 5 display.
    base = (c / 288 + 1) * 288 + 5*36 + 34;
    wait_c(base);
    chk("pre_rst_row5", re[0], 8'h20);
    rst = 1'b1;
    wait_n(1);
    chk("mid_rst_outs", {sd[0], sc[0], sl[0], fd[0], re[0]}, 0);
    chk("mid_rst_def", {sd[1], sc[1], sl[1], fd[1], re[1]}, 0);
    wait_n(2);
    rst = 1'b0;
    wait_c(34);
    chk("post_rst_row0", re[0], 8'h01);
    chk("post_rst_word", lat1[0], roww(data_t, 0));

    // Long run so the default instance completes two frames.
    for (int k = 0; k < 38; k++) begin
      data_t = rnd128();
      wait_n(500);
    end
    chk("def_gap_seen", (ngap[1] >= 1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Downstream consumer of the 128-bit digit bitmap (8 rows × 16 columns, four 4-column digit glyphs per row). Captures one full frame per refresh, multiplexes the LED matrix row by row, and serialises each row's 16 column bits into an external shift-register chain (74HC595 style) via data, shift-clock and latch pins. Sits between the bitmap generator and the board-level matrix pins.

## Interface
- CLK_DIV, 4, clk cycles per half-period of sr_clk; also the sr_latch pulse width; must be ≥1
- ROW_HOLD, 1000, clk cycles a row is displayed; must be ≥1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- data_t  input  128  frame bitmap; row r = data_t[127-16r : 112-16r], bit 127-16r = leftmost column
- sr_data  output  1  serial column data to shift chain
- sr_clk  output  1  shift clock; chain samples sr_data on rising edge
- sr_latch  output  1  storage-register latch pulse, active-high
- row_en  output  8  one-hot row drive, active-high; bit r = row r
- frame_done  output  1  one-cycle pulse at end of row 7 display

## Operation
- Internal: frame register (128), row counter (3 bits, wraps 7→0), 16-bit row shift register, bit counter (0..15), divider counter, hold counter.
- States: LOAD → SHIFT → LATCH → DISPLAY → LOAD.
- LOAD (1 cycle): if row==0, frame register ← data_t; row shift register ← frame row `row` (using the freshly captured value when row==0). row_en = 0.
- SHIFT: 16 bits, MSB (leftmost column) first. Per bit: sr_clk low for CLK_DIV cycles with sr_data = current bit, then high for CLK_DIV cycles; sr_data changes only on the cycle sr_clk returns low. After the 16th high phase: sr_clk → 0, go LATCH. row_en = 0.
- LATCH: sr_latch = 1 for CLK_DIV cycles, sr_clk = 0, row_en = 0.
- DISPLAY: row_en = 1<<row for ROW_HOLD cycles; sr_clk = sr_latch = 0. On the last cycle: row increments (wraps), and if row was 7, frame_done = 1 for that cycle; next state LOAD.
- Frame coherence: data_t changes after the row-0 LOAD are not shown until the next frame's row-0 LOAD.
- Blanking: row_en is all-zero in LOAD/SHIFT/LATCH; at most one bit set ever.
- No data-dependent behaviour: all-zero and all-one frames take identical timing.

## Timing
- Reset values (the cycle after a rst-high edge): sr_data=0, sr_clk=0, sr_latch=0, row_en=0, frame_done=0, row=0, state=LOAD.
- rst mid-operation: dominates any state; the next edge forces reset values and aborts any partial shift. First LOAD executes on the first edge with rst low.
- Row period = 1 + 32·CLK_DIV + CLK_DIV + ROW_HOLD cycles; defaults: 1+128+4+1000 = 1133.
- Frame period = 8 × row period; frame_done spacing equals the frame period.
- Latency data_t → visible on row 0: ≤ 1 frame period + (1 + 33·CLK_DIV) cycles.
- sr_data is stable CLK_DIV cycles before and CLK_DIV cycles after each sr_clk rising edge.
- Exactly 16 sr_clk rising edges per row, and exactly one sr_latch pulse per row, after the 16th rising edge.

## Test plan
- Reset: assert rst for 3 cycles during DISPLAY of row 5 → all outputs 0 on the next edge. After release, the first row shifted is row 0 and row_en=8'h01.
- Row mapping: data_t = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210. A bench model shifts on sr_clk and captures on sr_latch → rows 0..7 read 16'h0123, 4567, 89AB, CDEF, FEDC, BA98, 7654, 3210, with row_en 8'h01…8'h80 respectively.
- Timing, CLK_DIV=1, ROW_HOLD=2 → row period 36 cycles, sr_clk high/low 1 cycle each, sr_latch 1 cycle, frame_done every 288 cycles.
- Frame coherence: switch data_t from all-ones to all-zeros during row 3 DISPLAY → rows 3..7 still latch 16'hFFFF. The next frame latches 16'h0000 on all rows.
- Blanking invariant (random data_t, 20 frames): row_en==0 whenever sr_clk or sr_latch is 1, and $onehot0(row_en) at all times.
- Default parameters: frame_done spacing 9064 cycles; 16 sr_clk rising edges between consecutive sr_latch pulses.
